// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the iterative multiply/divide unit.
// Operation codes follow funct3; state names follow the control FSM.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      RUN,
      FIX,
      DONE
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// In divide mode the low accumulator half holds the dividend; quotient bits enter at bit 0.
module muldiv_step
   import riscv_pkg::*;
(
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   operand_i,
   input  logic              is_div_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic              q_bit_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem;
   logic [XLEN-1:0] rem_new;

   always_comb begin
      sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      rem     = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      rem_new = rem[XLEN-1:0];
      q_bit_o = 1'b0;
      acc_o   = {sum, acc_i[XLEN-1:1]};
      if (is_div_i) begin
         // True difference is below 2^XLEN, so the low bits alone are exact.
         if (rem >= {1'b0, operand_i}) begin
            rem_new = rem[XLEN-1:0] - operand_i;
            q_bit_o = 1'b1;
         end
         acc_o = {rem_new, acc_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Works on magnitudes and applies the sign and divide special cases in the FIX state.
module muldiv_unit
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero
);

   localparam int unsigned CntW = $clog2(XLEN);
   localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

   muldiv_state_t     state_q, state_d;
   muldiv_op_t        op_q, op_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              neg_res_q, neg_res_d;
   logic              b_zero_q, b_zero_d;
   logic              ovf_q, ovf_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              dbz_q, dbz_d;

   logic              sign_a, sign_b, sa, sb, is_div, accept;
   logic [2*XLEN-1:0] step_acc;
   logic              step_q_bit;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_res;

   muldiv_step u_step (
      .acc_i     (acc_q),
      .operand_i (b_q),
      .is_div_i  (is_div),
      .acc_o     (step_acc),
      .q_bit_o   (step_q_bit)
   );

   always_comb begin
      sign_a = (op_q == MULH) || (op_q == MULHSU) || (op_q == DIV) || (op_q == REM);
      sign_b = (op_q == MULH) || (op_q == DIV) || (op_q == REM);
      sa     = sign_a & a_q[XLEN-1];
      sb     = sign_b & b_q[XLEN-1];
      is_div = op_q[2];
   end

   // Sign fix and special-case override, consumed in FIX.
   always_comb begin
      prod    = neg_res_q ? -acc_q : acc_q;
      quo     = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem     = neg_res_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      fix_res = '0;
      unique case (op_q)
         MUL:                fix_res = prod[XLEN-1:0];
         MULH, MULHSU, MULHU: fix_res = prod[2*XLEN-1:XLEN];
         DIV, DIVU:          fix_res = b_zero_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quo);
         REM, REMU:          fix_res = b_zero_q ? a_q : (ovf_q ? '0 : rem);
         default:            fix_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      neg_res_d = neg_res_q;
      b_zero_d  = b_zero_q;
      ovf_d     = ovf_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
      accept    = start && ((state_q == IDLE) || (state_q == DONE));

      case (state_q)
         SETUP: begin
            acc_d     = {{XLEN{1'b0}}, (sa ? -a_q : a_q)};
            b_d       = sb ? -b_q : b_q;
            neg_res_d = ((op_q == REM) || (op_q == REMU)) ? sa : (sa ^ sb);
            b_zero_d  = (b_q == '0);
            ovf_d     = ((op_q == DIV) || (op_q == REM)) &&
                        (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
            cnt_d     = '0;
            state_d   = RUN;
         end
         RUN: begin
            acc_d = step_acc | {{(2*XLEN-1){1'b0}}, step_q_bit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) state_d = FIX;
         end
         FIX: begin
            result_d = fix_res;
            dbz_d    = is_div & b_zero_q;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         op_d    = muldiv_op_t'(op);
         a_d     = a;
         b_d     = b;
         dbz_d   = 1'b0;
         state_d = SETUP;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         op_q      <= MUL;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         neg_res_q <= 1'b0;
         b_zero_q  <= 1'b0;
         ovf_q     <= 1'b0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         neg_res_q <= neg_res_d;
         b_zero_q  <= b_zero_d;
         ovf_q     <= ovf_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = (state_q == SETUP) || (state_q == RUN) || (state_q == FIX);
   assign done        = (state_q == DONE);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake/reset cases,
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] result;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] prev_res;

   muldiv_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic dz);
      longint      sx, sy, ly;
      logic [63:0] ux, uy, p;
      int          ix, iy;
      logic        ovf;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ly  = longint'({32'b0, y});
      ux  = {32'b0, x};
      uy  = {32'b0, y};
      ix  = x;
      iy  = y;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      dz  = o[2] && (y == 0);
      r   = '0;
      case (o)
         3'd0: begin p = 64'(sx * sy); r = p[31:0];  end
         3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
         3'd2: begin p = 64'(sx * ly); r = p[63:32]; end
         3'd3: begin p = ux * uy;      r = p[63:32]; end
         3'd4: r = (y == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ix / iy));
         3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: r = (y == 0) ? x : (ovf ? 32'h0 : 32'(ix % iy));
         default: r = (y == 0) ? x : x % y;
      endcase
   endfunction

   // Drive a request; caller is positioned at a negedge. Returns just after the accept edge.
   task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic finish_op(input string tag, input logic [31:0] er, input logic ed, input bit poke);
      int k;
      int bc;
      k  = 1;
      bc = 0;
      @(negedge clk);
      check({tag, "_dz_clear"}, 32'(div_by_zero), 32'd0);
      check({tag, "_held"}, result, prev_res);
      while (!done && k < 45) begin
         if (busy) bc++;
         if (poke) begin
            start = (k >= 5 && k <= 7);
            op = 3'($urandom); a = $urandom; b = $urandom;
         end
         @(negedge clk);
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'd35);
      check({tag, "_busy_cycles"}, 32'(bc), 32'd34);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_result"}, result, er);
      check({tag, "_dz"}, 32'(div_by_zero), 32'(ed));
      prev_res = result;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic ed,
                         input bit poke);
      @(negedge clk);
      launch(o, x, y);
      finish_op(tag, er, ed, poke);
   endtask

   task automatic run_model(input string tag, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y);
      logic [31:0] er;
      logic        ed;
      model(o, x, y, er, ed);
      run_op(tag, o, x, y, er, ed, 1'b0);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [5];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'h0000_0001;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF;
      case ($urandom_range(0, 3))
         0:       return 32'($signed($urandom_range(0, 40)) - 20);
         1:       return specials[$urandom_range(0, 4)];
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      prev_res = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op("mul_neg", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op("mulhu_m1", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("mulh_m1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
      run_op("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
      run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
      run_op("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0);
      run_op("mul_after_dz", MUL, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
      run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
      run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);

      run_op("mul_poked", MUL, 32'd123, 32'd456, 32'd56088, 1'b0, 1'b1);

      // Second request lands in the DONE cycle of the first.
      run_op("b2b_first", DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0);
      launch(REMU, 32'd1000, 32'd3);
      finish_op("b2b_second", 32'd1, 1'b0, 1'b0);

      @(negedge clk);
      launch(MUL, 32'd9, 32'd9);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      prev_res = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_done", 32'(done), 32'd0);
      end
      run_model("after_rst", MULHU, 32'h1234_5678, 32'h9ABC_DEF0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  ro;
         logic [31:0] rx, ry;
         ro = 3'($urandom);
         rx = pick_operand();
         ry = pick_operand();
         run_model($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
